// File: rtl/dual_instr_fetch.sv
// Loadable instruction store that returns a registered instruction pair
// (mem[pc], mem[pc+1]) to the dual-issue core every unstalled RUN cycle.
module dual_instr_fetch #(
    parameter int              DEPTH    = 32,
    parameter int              AW       = 5,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic [AW-1:0] load_addr_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [AW-1:0] pc_i,
    input  logic          stall_i,
    output logic [DW-1:0] instruction_1_o,
    output logic [DW-1:0] instruction_2_o,
    output logic          fetch_valid_o,
    output logic [15:0]   fetch_count_o
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_ready_o = 1'b0;
        case (state)
            LOAD: begin
                load_ready_o = 1'b1;
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (stop_i) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // The store is writable only while loading; a write alongside start_i still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
        end else if (state == LOAD && load_valid_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_1_o <= NOP_WORD;
            instruction_2_o <= NOP_WORD;
            fetch_valid_o   <= 1'b0;
            fetch_count_o   <= 16'h0000;
        end else begin
            case (state)
                LOAD: begin
                    instruction_1_o <= NOP_WORD;
                    instruction_2_o <= NOP_WORD;
                    fetch_valid_o   <= 1'b0;
                    if (start_i) fetch_count_o <= 16'h0000;
                end
                RUN: begin
                    // stop flushes even when stalled; the count survives until the next start
                    if (stop_i) begin
                        instruction_1_o <= NOP_WORD;
                        instruction_2_o <= NOP_WORD;
                        fetch_valid_o   <= 1'b0;
                    end else if (!stall_i) begin
                        instruction_1_o <= mem[pc_i];
                        instruction_2_o <= (pc_i == LAST_ADDR) ? NOP_WORD : mem[pc_i + AW'(1)];
                        fetch_valid_o   <= 1'b1;
                        if (fetch_count_o != CNT_MAX) fetch_count_o <= fetch_count_o + 16'd1;
                    end
                end
                default: begin
                    fetch_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_instr_fetch.sv
// Scoreboard bench for dual_instr_fetch: the driver queues the expected pair
// for every fetch it issues; the monitor pops one entry per valid output cycle.
module tb_dual_instr_fetch;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid_i;
    logic          load_ready_o;
    logic [AW-1:0] load_addr_i;
    logic [DW-1:0] load_data_i;
    logic          start_i;
    logic          stop_i;
    logic [AW-1:0] pc_i;
    logic          stall_i;
    logic [DW-1:0] instruction_1_o;
    logic [DW-1:0] instruction_2_o;
    logic          fetch_valid_o;
    logic [15:0]   fetch_count_o;

    typedef struct {
        logic [DW-1:0] i1;
        logic [DW-1:0] i2;
        logic [15:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    dual_instr_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_valid_i    (load_valid_i),
        .load_ready_o    (load_ready_o),
        .load_addr_i     (load_addr_i),
        .load_data_i     (load_data_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .pc_i            (pc_i),
        .stall_i         (stall_i),
        .instruction_1_o (instruction_1_o),
        .instruction_2_o (instruction_2_o),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [DW-1:0] i1, input logic [DW-1:0] i2,
                               input logic [15:0] cnt);
        exp_t e;
        e.i1  = i1;
        e.i2  = i2;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_valid_i = 1'b1;
        load_addr_i  = a;
        load_data_i  = d;
        tick();
        load_valid_i = 1'b0;
    endtask

    // Monitor: every valid output cycle must match the oldest queued pair.
    always @(negedge clk) begin
        if (rst_n && fetch_valid_o) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 64'(fetch_valid_o), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pair", {instruction_1_o, instruction_2_o}, {e.i1, e.i2});
                check("count", 64'(fetch_count_o), 64'(e.cnt));
            end
        end
    end

    initial begin
        int k;
        rst_n        = 1'b0;
        load_valid_i = 1'b0;
        load_addr_i  = '0;
        load_data_i  = '0;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        pc_i         = '0;
        stall_i      = 1'b0;
        #12;
        check("rst_ready", 64'(load_ready_o), 64'd1);
        check("rst_instr", {instruction_1_o, instruction_2_o}, 64'd0);
        check("rst_valid", 64'(fetch_valid_o), 64'd0);
        check("rst_count", 64'(fetch_count_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // T1/T2: fill the store, start, fetch from 0 and from the last word
        load_word(5'd0, 32'h11);
        load_word(5'd1, 32'h22);
        load_word(5'd2, 32'h33);
        load_word(5'd3, 32'h44);
        load_word(5'd31, 32'hAB);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_no_valid", 64'(fetch_valid_o), 64'd0);
        check("run_ready", 64'(load_ready_o), 64'd0);
        pc_i = 5'd0;  expect_pair(32'h11, 32'h22, 16'd1); tick();
        pc_i = 5'd31; expect_pair(32'hAB, 32'h00, 16'd2); tick();

        // T3: stall freezes outputs and counter while pc moves
        pc_i = 5'd2;  expect_pair(32'h33, 32'h44, 16'd3); tick();
        stall_i = 1'b1;
        pc_i = 5'd3;
        for (int i = 0; i < 3; i++) begin
            expect_pair(32'h33, 32'h44, 16'd3);
            tick();
        end
        stall_i = 1'b0;
        expect_pair(32'h44, 32'h00, 16'd4); tick();

        // T4: writes are ignored in RUN; stop wins over stall
        load_valid_i = 1'b1;
        load_addr_i  = 5'd0;
        load_data_i  = 32'hDEAD_BEEF;
        check("run_load_ready", 64'(load_ready_o), 64'd0);
        pc_i = 5'd0;  expect_pair(32'h11, 32'h22, 16'd5); tick();
        load_valid_i = 1'b0;
        expect_pair(32'h11, 32'h22, 16'd6); tick();
        stop_i  = 1'b1;
        stall_i = 1'b1;
        tick();
        stop_i  = 1'b0;
        stall_i = 1'b0;
        check("stop_instr", {instruction_1_o, instruction_2_o}, 64'd0);
        check("stop_valid", 64'(fetch_valid_o), 64'd0);
        check("stop_ready", 64'(load_ready_o), 64'd1);
        check("stop_count_hold", 64'(fetch_count_o), 64'd6);

        // T5: a write in the start cycle is committed before the first fetch
        load_valid_i = 1'b1;
        load_addr_i  = 5'd0;
        load_data_i  = 32'h55;
        start_i      = 1'b1;
        tick();
        load_valid_i = 1'b0;
        start_i      = 1'b0;
        pc_i = 5'd0;  expect_pair(32'h55, 32'h22, 16'd1); tick();

        // T6: async reset mid-RUN clears outputs before any edge, then the store
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_instr", {instruction_1_o, instruction_2_o}, 64'd0);
        check("async_valid", 64'(fetch_valid_o), 64'd0);
        check("async_count", 64'(fetch_count_o), 64'd0);
        check("async_ready", 64'(load_ready_o), 64'd1);
        rst_n = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        pc_i = 5'd0;
        for (k = 1; k <= 70000; k++) begin
            expect_pair(32'h0, 32'h0, (k > 65535) ? 16'hFFFF : 16'(k));
            tick();
        end
        @(negedge clk);
        #1;
        check("count_saturated", 64'(fetch_count_o), 64'hFFFF);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
